// File: rtl/fpu_sequencer_pkg.sv
// Shared definitions for the FPU sequencer: widths, opcodes, FSM encoding and
// latency classes, plus the opcode decoder used by the latency lookup.
package fpu_sequencer_pkg;

  localparam int WORD   = 16;
  localparam int OPSIZE = 8;
  localparam int REGW   = 4;

  localparam logic [OPSIZE-1:0] OP_I2F   = 8'h20;
  localparam logic [OPSIZE-1:0] OP_II2PP = 8'h21;
  localparam logic [OPSIZE-1:0] OP_F2I   = 8'h22;
  localparam logic [OPSIZE-1:0] OP_PP2II = 8'h23;
  localparam logic [OPSIZE-1:0] OP_INVF  = 8'h24;
  localparam logic [OPSIZE-1:0] OP_INVPP = 8'h25;
  localparam logic [OPSIZE-1:0] OP_F2PP  = 8'h26;
  localparam logic [OPSIZE-1:0] OP_PP2F  = 8'h27;
  localparam logic [OPSIZE-1:0] OP_NEGF  = 8'h28;
  localparam logic [OPSIZE-1:0] OP_ADDF  = 8'h60;
  localparam logic [OPSIZE-1:0] OP_ADDPP = 8'h61;
  localparam logic [OPSIZE-1:0] OP_MULF  = 8'h62;
  localparam logic [OPSIZE-1:0] OP_MULPP = 8'h63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_CVT = 2'd0,
    CLS_ADD = 2'd1,
    CLS_MUL = 2'd2,
    CLS_INV = 2'd3
  } lat_class_e;

  typedef struct packed {
    logic       legal;
    lat_class_e cls;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [OPSIZE-1:0] op);
    op_info_t info;
    info.legal = 1'b1;
    info.cls   = CLS_CVT;
    case (op)
      OP_I2F, OP_II2PP, OP_F2I, OP_PP2II,
      OP_F2PP, OP_PP2F, OP_NEGF: info.cls = CLS_CVT;
      OP_INVF, OP_INVPP:         info.cls = CLS_INV;
      OP_ADDF, OP_ADDPP:         info.cls = CLS_ADD;
      OP_MULF, OP_MULPP:         info.cls = CLS_MUL;
      default:                   info.legal = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/fpu_sequencer_lat_lut.sv
// Combinational opcode lookup: legality flag and per-class latency in cycles.
module fpu_lat_lut
  import fpu_sequencer_pkg::*;
#(
  parameter int unsigned LAT_CVT = 1,
  parameter int unsigned LAT_ADD = 2,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_INV = 6
) (
  input  logic [OPSIZE-1:0] op,
  output logic              legal,
  output logic [3:0]        lat
);

  op_info_t info;

  always_comb begin
    info  = decode_op(op);
    legal = info.legal;
    lat   = 4'(LAT_CVT);
    case (info.cls)
      CLS_CVT: lat = 4'(LAT_CVT);
      CLS_ADD: lat = 4'(LAT_ADD);
      CLS_MUL: lat = 4'(LAT_MUL);
      CLS_INV: lat = 4'(LAT_INV);
      default: lat = 4'(LAT_CVT);
    endcase
  end

endmodule

// File: rtl/fpu_sequencer.sv
// Runs one multi-cycle FPU op at a time for stage 2, holds the result until
// acked, and flags RAW hazards against the in-flight destination.
//
//  state | meaning
//  IDLE  | no op in flight, ready for a request
//  RUN   | FPU core working, counting down the op latency
//  DONE  | result held on wb_* until stage 2 acks it
module fpu_sequencer
  import fpu_sequencer_pkg::*;
#(
  parameter int unsigned LAT_CVT = 1,
  parameter int unsigned LAT_ADD = 2,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_INV = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPSIZE-1:0] req_op,
  input  logic [REGW-1:0]   req_rd,
  input  logic [WORD-1:0]   req_a,
  input  logic [WORD-1:0]   req_b,
  output logic              fpu_start,
  output logic [OPSIZE-1:0] fpu_op,
  output logic [WORD-1:0]   fpu_a,
  output logic [WORD-1:0]   fpu_b,
  input  logic [WORD-1:0]   fpu_res,
  output logic              wb_valid,
  output logic [REGW-1:0]   wb_reg,
  output logic [WORD-1:0]   wb_data,
  input  logic              wb_ack,
  input  logic [REGW-1:0]   chk_ra,
  input  logic [REGW-1:0]   chk_rb,
  output logic              hazard,
  output logic              busy,
  output logic              bad_op
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OPSIZE-1:0] op_q, op_d;
  logic [WORD-1:0]   a_q, a_d, b_q, b_d;
  logic [REGW-1:0]   rd_q, rd_d;
  logic [REGW-1:0]   wb_reg_q, wb_reg_d;
  logic [WORD-1:0]   wb_data_q, wb_data_d;
  logic              wb_valid_q, wb_valid_d;
  logic              fpu_start_q, fpu_start_d;
  logic              bad_op_q, bad_op_d;
  logic              pending_q, pending_d;

  logic              op_legal;
  logic [3:0]        op_lat;
  logic              accept;

  fpu_lat_lut #(
    .LAT_CVT (LAT_CVT),
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_INV (LAT_INV)
  ) u_lat_lut (
    .op    (req_op),
    .legal (op_legal),
    .lat   (op_lat)
  );

  assign req_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & wb_ack);
  assign accept    = req_valid & req_ready & op_legal;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    wb_valid_d  = wb_valid_q;
    pending_d   = pending_q;
    fpu_start_d = 1'b0;
    bad_op_d    = req_valid & req_ready & ~op_legal;

    case (state_q)
      ST_RUN: begin
        if (cnt_q == 4'd0) begin
          wb_data_d  = fpu_res;
          wb_reg_d   = rd_q;
          wb_valid_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (wb_ack) begin
          wb_valid_d = 1'b0;
          pending_d  = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new accept overrides the DONE->IDLE return for back-to-back ops.
    if (accept) begin
      state_d     = ST_RUN;
      op_d        = req_op;
      a_d         = req_a;
      b_d         = req_b;
      rd_d        = req_rd;
      cnt_d       = op_lat - 4'd1;
      fpu_start_d = 1'b1;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      wb_valid_q  <= 1'b0;
      fpu_start_q <= 1'b0;
      bad_op_q    <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      wb_valid_q  <= wb_valid_d;
      fpu_start_q <= fpu_start_d;
      bad_op_q    <= bad_op_d;
      pending_q   <= pending_d;
    end
  end

  assign fpu_start = fpu_start_q;
  assign fpu_op    = op_q;
  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
  assign wb_valid  = wb_valid_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;
  assign bad_op    = bad_op_q;
  assign busy      = (state_q != ST_IDLE);
  assign hazard    = pending_q & ((chk_ra == rd_q) | (chk_rb == rd_q));

endmodule

// File: tb/tb_fpu_sequencer.sv
// Bench for fpu_sequencer: a time-based reference model checks every cycle,
// a vector table checks per-opcode latency/results, plus hand-written corners.
module tb_fpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, wb_ack;
  logic [7:0]  req_op;
  logic [3:0]  req_rd, chk_ra, chk_rb;
  logic [15:0] req_a, req_b, fpu_res;

  logic        req_ready, fpu_start, wb_valid, hazard, busy, bad_op;
  logic [7:0]  fpu_op;
  logic [15:0] fpu_a, fpu_b, wb_data;
  logic [3:0]  wb_reg;

  logic        req_ready2, fpu_start2, wb_valid2, hazard2, busy2, bad_op2;
  logic [7:0]  fpu_op2;
  logic [15:0] fpu_a2, fpu_b2, wb_data2;
  logic [3:0]  wb_reg2;

  always #5 clk = ~clk;

  fpu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rd(req_rd),
    .req_a(req_a), .req_b(req_b),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_res(fpu_res),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ack(wb_ack),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .hazard(hazard), .busy(busy), .bad_op(bad_op)
  );

  fpu_sequencer #(.LAT_ADD(1)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready2), .req_op(req_op), .req_rd(req_rd),
    .req_a(req_a), .req_b(req_b),
    .fpu_start(fpu_start2), .fpu_op(fpu_op2), .fpu_a(fpu_a2), .fpu_b(fpu_b2), .fpu_res(fpu_res),
    .wb_valid(wb_valid2), .wb_reg(wb_reg2), .wb_data(wb_data2), .wb_ack(wb_ack),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .hazard(hazard2), .busy(busy2), .bad_op(bad_op2)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: an op accepted at edge t publishes its result at edge t+LAT.
  bit          m_run, m_wbv, m_pend, m_start, m_bad;
  logic [3:0]  m_rd, m_wbr;
  logic [15:0] m_wbd, m_a, m_b;
  logic [7:0]  m_op;
  int          t, m_done_at;

  bit          obs_wbv, obs_ready, obs_busy, obs_haz, obs_start, obs_bad, obs_wbv2, obs_haz2;
  logic [15:0] obs_wbd;
  logic [3:0]  obs_wbr;

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    bit          legal;
    int          edges;
  } vec_t;

  vec_t vecs[13];
  logic [7:0] legal_ops[13] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                8'h27, 8'h28, 8'h60, 8'h61, 8'h62, 8'h63};

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic bit ref_legal(input logic [7:0] op);
    return (op >= 8'h20 && op <= 8'h28) || (op >= 8'h60 && op <= 8'h63);
  endfunction

  function automatic int ref_lat(input logic [7:0] op);
    if (op == 8'h24 || op == 8'h25) return 6;
    if (op == 8'h62 || op == 8'h63) return 3;
    if (op == 8'h60 || op == 8'h61) return 2;
    return 1;
  endfunction

  task automatic model_clear();
    m_run = 0; m_wbv = 0; m_pend = 0; m_start = 0; m_bad = 0;
    m_rd = '0; m_wbr = '0; m_wbd = '0; m_a = '0; m_b = '0; m_op = '0;
    m_done_at = 0;
  endtask

  task automatic cycle(input bit v, input logic [7:0] op, input logic [3:0] rd,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                       input bit ack, input logic [3:0] ra, input logic [3:0] rb);
    bit exp_ready, acc;
    @(negedge clk);
    req_valid = v; req_op = op; req_rd = rd; req_a = a; req_b = b;
    fpu_res = res; wb_ack = ack; chk_ra = ra; chk_rb = rb;
    #1;
    exp_ready = !(m_run || m_wbv) || (m_wbv && ack);
    check("req_ready", int'(req_ready), int'(exp_ready));
    check("hazard", int'(hazard), int'(m_pend && (ra == m_rd || rb == m_rd)));
    check("busy", int'(busy), int'(m_run || m_wbv));
    check("fpu_start", int'(fpu_start), int'(m_start));
    check("bad_op", int'(bad_op), int'(m_bad));
    check("wb_valid", int'(wb_valid), int'(m_wbv));
    check("wb_reg", int'(wb_reg), int'(m_wbr));
    check("wb_data", int'(wb_data), int'(m_wbd));
    check("fpu_op", int'(fpu_op), int'(m_op));
    check("fpu_a", int'(fpu_a), int'(m_a));
    check("fpu_b", int'(fpu_b), int'(m_b));
    obs_wbv = wb_valid; obs_ready = req_ready; obs_busy = busy; obs_haz = hazard;
    obs_start = fpu_start; obs_bad = bad_op; obs_wbd = wb_data; obs_wbr = wb_reg;
    obs_wbv2 = wb_valid2; obs_haz2 = hazard2;

    acc   = v && exp_ready && ref_legal(op);
    m_bad = v && exp_ready && !ref_legal(op);
    if (m_run && t == m_done_at) begin
      m_run = 0; m_wbv = 1; m_wbr = m_rd; m_wbd = res;
    end else if (m_wbv && ack) begin
      m_wbv = 0; m_pend = 0;
    end
    if (acc) begin
      m_run = 1; m_done_at = t + ref_lat(op);
      m_op = op; m_a = a; m_b = b; m_rd = rd; m_pend = 1;
    end
    m_start = acc;
    t++;
  endtask

  task automatic idle(input bit ack, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [15:0] res);
    cycle(1'b0, 8'h00, 4'd0, 16'h0, 16'h0, res, ack, ra, rb);
  endtask

  // k = edges counted from the accept edge (inclusive) to the one raising wb_valid.
  task automatic wait_wb(input logic [3:0] ra, input logic [3:0] rb, input logic [15:0] res,
                         output int k);
    k = 0;
    do begin
      idle(1'b0, ra, rb, res);
      k++;
    end while (!obs_wbv && k < 20);
    if (!obs_wbv) check("wb_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0]  = '{8'h20, 4'd3, 16'h0005, 16'h0000, 16'h4500, 1'b1, 2};
    vecs[1]  = '{8'h24, 4'd6, 16'h3C00, 16'h0000, 16'h3800, 1'b1, 7};
    vecs[2]  = '{8'h62, 4'hA, 16'h4000, 16'h4200, 16'h4600, 1'b1, 4};
    vecs[3]  = '{8'h60, 4'd1, 16'h3C00, 16'h3C00, 16'h4000, 1'b1, 3};
    vecs[4]  = '{8'h28, 4'd2, 16'hC000, 16'h0000, 16'h4000, 1'b1, 2};
    vecs[5]  = '{8'h27, 4'hF, 16'h1234, 16'h5678, 16'h9ABC, 1'b1, 2};
    vecs[6]  = '{8'h25, 4'd4, 16'h0101, 16'h0202, 16'h0303, 1'b1, 7};
    vecs[7]  = '{8'h63, 4'd8, 16'h7777, 16'h8888, 16'hCAFE, 1'b1, 4};
    vecs[8]  = '{8'h61, 4'hC, 16'h0F0F, 16'hF0F0, 16'hD00D, 1'b1, 3};
    vecs[9]  = '{8'h70, 4'd5, 16'h1111, 16'h2222, 16'h0000, 1'b0, 0};
    vecs[10] = '{8'h29, 4'd5, 16'h1111, 16'h2222, 16'h0000, 1'b0, 0};
    vecs[11] = '{8'h1F, 4'd5, 16'h1111, 16'h2222, 16'h0000, 1'b0, 0};
    vecs[12] = '{8'h64, 4'd5, 16'h1111, 16'h2222, 16'h0000, 1'b0, 0};

    t = 0;
    model_clear();
    reset = 1'b0; req_valid = 0; req_op = 0; req_rd = 0; req_a = 0; req_b = 0;
    fpu_res = 0; wb_ack = 0; chk_ra = 0; chk_rb = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of a mulf drops the op
    cycle(1'b1, 8'h62, 4'd7, 16'h0102, 16'h0304, 16'h0, 1'b0, 4'd7, 4'd7);
    idle(1'b0, 4'd7, 4'd7, 16'h0);
    @(negedge clk);
    req_valid = 0; wb_ack = 0; chk_ra = 4'd7; chk_rb = 4'd7;
    #2 reset = 1'b0;
    #1;
    check("rst_fpu_start", int'(fpu_start), 0);
    check("rst_wb_valid", int'(wb_valid), 0);
    check("rst_bad_op", int'(bad_op), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wb_reg", int'(wb_reg), 0);
    check("rst_wb_data", int'(wb_data), 0);
    check("rst_fpu_op", int'(fpu_op), 0);
    check("rst_fpu_a", int'(fpu_a), 0);
    check("rst_fpu_b", int'(fpu_b), 0);
    check("rst_hazard", int'(hazard), 0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    idle(1'b0, 4'd7, 4'd7, 16'h0);
    check("rst_ready_after", int'(obs_ready), 1);

    // Per-opcode vector table
    for (int i = 0; i < 13; i++) begin
      cycle(1'b1, vecs[i].op, vecs[i].rd, vecs[i].a, vecs[i].b, 16'h0, 1'b0, 4'd0, 4'd0);
      if (vecs[i].legal) begin
        wait_wb(vecs[i].rd, 4'd0, vecs[i].res, k);
        check($sformatf("lat_%0h", vecs[i].op), k, vecs[i].edges);
        check($sformatf("wbdata_%0h", vecs[i].op), int'(obs_wbd), int'(vecs[i].res));
        check($sformatf("wbreg_%0h", vecs[i].op), int'(obs_wbr), int'(vecs[i].rd));
        check($sformatf("haz_done_%0h", vecs[i].op), int'(obs_haz), 1);
        idle(1'b1, vecs[i].rd, 4'd0, 16'h0);
        idle(1'b0, vecs[i].rd, 4'd0, 16'h0);
        check($sformatf("haz_after_ack_%0h", vecs[i].op), int'(obs_haz), 0);
      end else begin
        idle(1'b0, 4'd0, 4'd0, 16'h0);
        check($sformatf("bad_pulse_%0h", vecs[i].op), int'(obs_bad), 1);
        check($sformatf("bad_nostart_%0h", vecs[i].op), int'(obs_start), 0);
        check($sformatf("bad_idle_%0h", vecs[i].op), int'(obs_busy), 0);
        idle(1'b0, 4'd0, 4'd0, 16'h0);
        check($sformatf("bad_once_%0h", vecs[i].op), int'(obs_bad), 0);
      end
    end

    // Hold DONE without ack, then ack with a back-to-back addf
    cycle(1'b1, 8'h62, 4'd5, 16'h4000, 16'h4000, 16'h0, 1'b0, 4'd0, 4'd0);
    wait_wb(4'd0, 4'd0, 16'h1234, k);
    repeat (5) begin
      cycle(1'b1, 8'h60, 4'd9, 16'hAAAA, 16'h5555, 16'hBEEF, 1'b0, 4'd0, 4'd0);
      check("hold_wb_data", int'(obs_wbd), 16'h1234);
      check("hold_wb_valid", int'(obs_wbv), 1);
      check("hold_ready", int'(obs_ready), 0);
    end
    cycle(1'b1, 8'h60, 4'd9, 16'h1111, 16'h2222, 16'h0, 1'b1, 4'd5, 4'd5);
    check("b2b_ready", int'(obs_ready), 1);
    idle(1'b0, 4'd9, 4'd0, 16'h0);
    check("b2b_start", int'(obs_start), 1);
    check("b2b_busy", int'(obs_busy), 1);
    check("b2b_haz_new", int'(obs_haz), 1);
    check("b2b_wbv_low", int'(obs_wbv), 0);
    idle(1'b0, 4'd5, 4'd5, 16'h0);
    check("b2b_haz_old", int'(obs_haz), 0);
    wait_wb(4'd9, 4'd0, 16'h4455, k);
    check("b2b_wb_reg", int'(obs_wbr), 9);
    idle(1'b1, 4'd0, 4'd0, 16'h0);

    // LAT_ADD=1 instance: addpp completes one edge after accept
    @(negedge clk);
    reset = 1'b0; req_valid = 0; wb_ack = 0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 8'h61, 4'd6, 16'h0A0A, 16'h0B0B, 16'h0, 1'b0, 4'd0, 4'd6);
    k = 0;
    do begin
      idle(1'b0, 4'd0, 4'd6, 16'h5A5A);
      k++;
      if (k == 1) check("lat1_haz_rb", int'(obs_haz2), 1);
    end while (!obs_wbv2 && k < 20);
    check("lat1_addpp_edges", k, 2);
    wait_wb(4'd0, 4'd6, 16'h5A5A, k);
    idle(1'b1, 4'd0, 4'd6, 16'h0);
    idle(1'b0, 4'd0, 4'd6, 16'h0);
    check("lat1_wb_reg", int'(wb_reg2), 6);
    check("lat1_wb_data", int'(wb_data2), 16'h5A5A);
    check("lat1_wb_valid", int'(wb_valid2), 0);
    check("lat1_busy", int'(busy2), 0);
    check("lat1_ready", int'(req_ready2), 1);
    check("lat1_start", int'(fpu_start2), 0);
    check("lat1_bad", int'(bad_op2), 0);
    check("lat1_hazard", int'(hazard2), 0);
    check("lat1_fpu_op", int'(fpu_op2), 16'h61);
    check("lat1_fpu_a", int'(fpu_a2), 16'h0A0A);
    check("lat1_fpu_b", int'(fpu_b2), 16'h0B0B);

    // Randomised traffic against the model
    repeat (600) begin
      logic [7:0] op;
      op = ($urandom_range(0, 4) == 0) ? 8'($urandom) : legal_ops[$urandom_range(0, 12)];
      cycle(1'($urandom_range(0, 1)), op, 4'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), ($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
